// File: rtl/pipe_delay_line.sv
// -----------------------------------------------------------------------------
// pipe_delay_line
//
// Fixed-latency delay line. It delays a WIDTH-bit value and a 1-bit strobe
// through STAGES register stages in lockstep. There is no flow control.
// Typical use is to align control or handshake vectors (start -> done) with
// datapath latency.
//
// Parameters:
//   STAGES : delay in clock cycles. The legal range is 0..64. With 0 the block
//            is a combinational pass-through.
//   WIDTH  : width of val_in / val_out. Must be at least 1.
//
// Ports:
//   clk      : system clock. All state changes on the rising edge.
//   reset    : synchronous, active-low. Clears every stage.
//   en       : shift enable. This port exists only when
//              PIPE_DELAY_LINE_CLKEN_EN is defined.
//   pipe_in  : strobe, delayed together with val_in.
//   pipe_out : pipe_in delayed by STAGES cycles.
//   val_in   : value to delay.
//   val_out  : val_in delayed by STAGES cycles.
//
// Optional feature (macro PIPE_DELAY_LINE_CLKEN_EN):
//   Adds the en port. The chain advances only on edges where en = 1.
//   Reset clears the chain regardless of en.
//   When the macro is undefined, the chain shifts on every edge.
// -----------------------------------------------------------------------------
module pipe_delay_line #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_DELAY_LINE_CLKEN_EN
  input  logic             en,
`endif
  input  logic             pipe_in,
  output logic             pipe_out,
  input  logic [WIDTH-1:0] val_in,
  output logic [WIDTH-1:0] val_out
);

  // The shift-enable qualifier is a constant 1 when the feature is compiled
  // out. Synthesis then folds it away.
  logic shift_en;
`ifdef PIPE_DELAY_LINE_CLKEN_EN
  assign shift_en = en;
`else
  assign shift_en = 1'b1;
`endif

  if (STAGES == 0) begin : g_bypass
    // No registers exist here, so reset and en have no effect.
    assign val_out  = val_in;
    assign pipe_out = pipe_in;
  end else begin : g_chain
    // Each stage holds {pipe, val}. Stage 0 is the youngest entry.
    // The initialiser gives an all-zero power-up state before any reset.
    logic [STAGES-1:0][WIDTH:0] stage_q = '0;
    logic [STAGES-1:0][WIDTH:0] stage_d;

    always_comb begin
      // NOTE: assign a default first so every path writes stage_d;
      // otherwise the en = 0 path would infer a latch.
      stage_d = stage_q;
      if (shift_en) begin
        stage_d[0] = {pipe_in, val_in};
        for (int k = 1; k < int'(STAGES); k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end
    end

    // Reset wins over capture on the same edge.
    // The chain has a reset, so it maps to plain flops rather than SRLs.
    always_ff @(posedge clk) begin
      // NOTE: use non-blocking assignments so all stages see pre-edge values.
      if (!reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign {pipe_out, val_out} = stage_q[STAGES-1];
  end

endmodule

// File: tb/tb_pipe_delay_line.sv
// -----------------------------------------------------------------------------
// tb_pipe_delay_line
//
// Directed bench for pipe_delay_line. It instantiates several configurations,
// each with its own reset:
//   u1 : STAGES=1, WIDTH=2   single-cycle start->done alignment
//   u4 : STAGES=4, WIDTH=8   streaming, and reset while data is in flight
//   u0 : STAGES=0, WIDTH=36  combinational pass-through
//   u3 : STAGES=3, WIDTH=1   inputs tied to zero
//   u2 : STAGES=2, WIDTH=8   clock enable (built only with the macro)
//
// Inputs change #1 after a rising edge. Outputs are compared at that same
// point, so each comparison reflects the edge that just happened.
// -----------------------------------------------------------------------------
module tb_pipe_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // u1
  logic       rst1 = 1'b0;
  logic       p1_i = 1'b0;
  logic       p1_o;
  logic [1:0] v1_i = '0;
  logic [1:0] v1_o;

  // u4
  logic       rst4 = 1'b0;
  logic       p4_i = 1'b0;
  logic       p4_o;
  logic [7:0] v4_i = '0;
  logic [7:0] v4_o;

  // u0
  logic        rst0 = 1'b1;
  logic        p0_i = 1'b0;
  logic        p0_o;
  logic [35:0] v0_i = '0;
  logic [35:0] v0_o;

  // u3
  logic       rst3 = 1'b1;
  logic       p3_o;
  logic [0:0] v3_o;
  logic       zero_p = 1'b0;
  logic [0:0] zero_v = '0;

`ifdef PIPE_DELAY_LINE_CLKEN_EN
  logic       en1 = 1'b1;
  logic       en4 = 1'b1;
  logic       en0 = 1'b1;
  logic       en3 = 1'b1;
  logic       rst2 = 1'b0;
  logic       en2 = 1'b1;
  logic       p2_i = 1'b0;
  logic       p2_o;
  logic [7:0] v2_i = '0;
  logic [7:0] v2_o;

  pipe_delay_line #(.STAGES(1), .WIDTH(2)) u1 (
    .clk(clk), .reset(rst1), .en(en1),
    .pipe_in(p1_i), .pipe_out(p1_o), .val_in(v1_i), .val_out(v1_o));
  pipe_delay_line #(.STAGES(4), .WIDTH(8)) u4 (
    .clk(clk), .reset(rst4), .en(en4),
    .pipe_in(p4_i), .pipe_out(p4_o), .val_in(v4_i), .val_out(v4_o));
  pipe_delay_line #(.STAGES(0), .WIDTH(36)) u0 (
    .clk(clk), .reset(rst0), .en(en0),
    .pipe_in(p0_i), .pipe_out(p0_o), .val_in(v0_i), .val_out(v0_o));
  pipe_delay_line #(.STAGES(3), .WIDTH(1)) u3 (
    .clk(clk), .reset(rst3), .en(en3),
    .pipe_in(zero_p), .pipe_out(p3_o), .val_in(zero_v), .val_out(v3_o));
  pipe_delay_line #(.STAGES(2), .WIDTH(8)) u2 (
    .clk(clk), .reset(rst2), .en(en2),
    .pipe_in(p2_i), .pipe_out(p2_o), .val_in(v2_i), .val_out(v2_o));
`else
  pipe_delay_line #(.STAGES(1), .WIDTH(2)) u1 (
    .clk(clk), .reset(rst1),
    .pipe_in(p1_i), .pipe_out(p1_o), .val_in(v1_i), .val_out(v1_o));
  pipe_delay_line #(.STAGES(4), .WIDTH(8)) u4 (
    .clk(clk), .reset(rst4),
    .pipe_in(p4_i), .pipe_out(p4_o), .val_in(v4_i), .val_out(v4_o));
  pipe_delay_line #(.STAGES(0), .WIDTH(36)) u0 (
    .clk(clk), .reset(rst0),
    .pipe_in(p0_i), .pipe_out(p0_o), .val_in(v0_i), .val_out(v0_o));
  pipe_delay_line #(.STAGES(3), .WIDTH(1)) u3 (
    .clk(clk), .reset(rst3),
    .pipe_in(zero_p), .pipe_out(p3_o), .val_in(zero_v), .val_out(v3_o));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- Test 5 (power-up part): tied-zero instance before any reset ----
    #1;
    chk("u3_pwrup_val", 64'(v3_o), 64'h0);
    chk("u3_pwrup_pipe", 64'(p3_o), 64'h0);

    // ---- Test 1: STAGES=1 ----
    // Reset is held low for the first two edges.
    tick();
    tick();
    chk("t1_rst_val", 64'(v1_o), 64'h0);
    chk("t1_rst_pipe", 64'(p1_o), 64'h0);
    rst1 = 1'b1;
    tick();
    chk("t1_before", 64'(v1_o), 64'h0);
    v1_i = 2'b01;
    p1_i = 1'b1;
    tick();  // edge N captures 01
    chk("t1_done_val", 64'(v1_o), 64'h1);
    chk("t1_done_pipe", 64'(p1_o), 64'h1);
    v1_i = 2'b00;
    p1_i = 1'b0;
    tick();
    chk("t1_after_val", 64'(v1_o), 64'h0);
    chk("t1_after_pipe", 64'(p1_o), 64'h0);

    // ---- Test 2: STAGES=4, stream 0x01..0x10 ----
    // u4 has been held in reset so far.
    chk("t2_rst_val", 64'(v4_o), 64'h0);
    rst4 = 1'b1;
    v4_i = 8'h01;
    p4_i = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();  // edge k captures value k when k <= 16
      if (k >= 4 && k <= 19) begin
        chk($sformatf("t2_val_e%0d", k), 64'(v4_o), 64'(k - 3));
        chk($sformatf("t2_pipe_e%0d", k), 64'(p4_o), 64'h1);
      end else begin
        chk($sformatf("t2_val_e%0d", k), 64'(v4_o), 64'h0);
        chk($sformatf("t2_pipe_e%0d", k), 64'(p4_o), 64'h0);
      end
      if (k + 1 <= 16) begin
        v4_i = 8'(k + 1);
        p4_i = 1'b1;
      end else begin
        v4_i = 8'h00;
        p4_i = 1'b0;
      end
    end

    // ---- Test 3: reset while three values are in flight ----
    v4_i = 8'h21; p4_i = 1'b1; tick();
    v4_i = 8'h22; tick();
    v4_i = 8'h23; tick();
    chk("t3_inflight_val", 64'(v4_o), 64'h0);
    // Reset and a capture collide on this edge. Reset must win.
    v4_i = 8'h24;
    rst4 = 1'b0;
    tick();
    chk("t3_rst_val", 64'(v4_o), 64'h0);
    chk("t3_rst_pipe", 64'(p4_o), 64'h0);
    rst4 = 1'b1;
    v4_i = 8'h31;
    p4_i = 1'b1;
    tick();  // first edge after release captures 0x31
    v4_i = 8'h00;
    p4_i = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk($sformatf("t3_gap_val%0d", k), 64'(v4_o), 64'h0);
      chk($sformatf("t3_gap_pipe%0d", k), 64'(p4_o), 64'h0);
    end
    tick();
    chk("t3_new_val", 64'(v4_o), 64'h31);
    chk("t3_new_pipe", 64'(p4_o), 64'h1);
    tick();
    chk("t3_tail_val", 64'(v4_o), 64'h0);

    // ---- Test 4: STAGES=0 pass-through ----
    v0_i = 36'hFFFFFFFFF;
    p0_i = 1'b1;
    #1;
    chk("t4_comb_val", 64'(v0_o), 64'hFFFFFFFFF);
    chk("t4_comb_pipe", 64'(p0_o), 64'h1);
    rst0 = 1'b0;
    tick();
    chk("t4_rst_val", 64'(v0_o), 64'hFFFFFFFFF);
    chk("t4_rst_pipe", 64'(p0_o), 64'h1);
    v0_i = 36'h123456789;
    p0_i = 1'b0;
    #1;
    chk("t4_change_val", 64'(v0_o), 64'h123456789);
    chk("t4_change_pipe", 64'(p0_o), 64'h0);

    // ---- Test 5: tied-zero inputs through reset and free run ----
    rst3 = 1'b0;
    tick();
    rst3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5_val%0d", k), 64'(v3_o), 64'h0);
      chk($sformatf("t5_pipe%0d", k), 64'(p3_o), 64'h0);
    end

`ifdef PIPE_DELAY_LINE_CLKEN_EN
    // ---- Test 6: clock enable, STAGES=2 ----
    rst2 = 1'b0;
    tick();
    rst2 = 1'b1;
    en2  = 1'b1;
    v2_i = 8'hA5;
    p2_i = 1'b1;
    tick();  // first enabled edge
    chk("t6_first_val", 64'(v2_o), 64'h0);
    en2  = 1'b0;
    v2_i = 8'h00;
    p2_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6_hold%0d", k), 64'(v2_o), 64'h0);
    end
    en2 = 1'b1;
    tick();  // second enabled edge
    chk("t6_out_val", 64'(v2_o), 64'hA5);
    chk("t6_out_pipe", 64'(p2_o), 64'h1);
    tick();
    chk("t6_drain_val", 64'(v2_o), 64'h0);
    v2_i = 8'h5A;
    p2_i = 1'b1;
    tick();
    v2_i = 8'h00;
    p2_i = 1'b0;
    tick();
    chk("t6_second_val", 64'(v2_o), 64'h5A);
    en2 = 1'b0;
    tick();
    chk("t6_frozen_val", 64'(v2_o), 64'h5A);
    rst2 = 1'b0;
    tick();
    chk("t6_rst_en0_val", 64'(v2_o), 64'h0);
    chk("t6_rst_en0_pipe", 64'(p2_o), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_delay_line.md
Name: pipe_delay_line

Overview:
- Parameterised fixed-latency delay line.
- Carries a WIDTH-bit value bus and a 1-bit pipe strobe through STAGES register stages.
- Used throughout the tracking firmware to align control and handshake vectors (e.g. start -> done) with datapath latency.
- Purely synchronous shift register; no flow control.

Parameters:
- STAGES, 1, number of clock cycles of delay (0 allowed = combinational pass-through; legal range 0..64).
- WIDTH, 1, bit width of val_in/val_out (>=1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (low = clear pipeline on next rising clk edge).
- pipe_in  input  1  strobe/valid bit delayed in lockstep with val_in; may be left unconnected (treated as 0).
- pipe_out  output  1  pipe_in delayed by STAGES cycles; may be left unconnected.
- val_in  input  WIDTH  value to delay; may be left unconnected (treated as 0).
- val_out  output  WIDTH  val_in delayed by exactly STAGES cycles.

Behaviour:
- Internal chain of STAGES registers, each WIDTH+1 bits ({pipe, val}).
- Every rising clk with reset high:
  - stage[0] <= {pipe_in, val_in};
  - stage[k] <= stage[k-1] for k = 1..STAGES-1.
- Outputs: val_out/pipe_out = stage[STAGES-1].
- Latency: value present at edge N appears on outputs after edge N+STAGES-1 is completed, i.e. visible from edge N+STAGES onward. Throughput one value per cycle, no bubbles, no backpressure.
- Reset:
  - On a rising clk with reset low, every stage clears to 0.
  - Hence val_out = 0 and pipe_out = 0 from the cycle after reset is sampled low.
  - Reset mid-stream discards all in-flight values; capture restarts on the first edge with reset high (that edge captures the current inputs).
  - Reset takes priority over capture when both apply on the same edge.
- Power-up: all stages initialise to 0, so outputs are 0 before any reset.
- STAGES = 0:
  - val_out = val_in and pipe_out = pipe_in combinationally.
  - reset has no effect; no registers are inferred.
- Data is not interpreted. Any bit pattern, including all-ones, passes unchanged; no arithmetic, no wrap concerns.
- pipe and val paths use identical stage count; their relative alignment is always preserved.
- Unconnected inputs tie to 0, so the corresponding outputs stay 0 indefinitely.
- Synthesis: implement as plain flops; SRL inference is allowed only when no reset is applied to the chain, so the default is flops.

Optional Feature:
- Macro: PIPE_DELAY_LINE_CLKEN_EN.
- When defined:
  - Adds input port en (1 bit, placed after reset).
  - Shifting (capture and advance) occurs only on edges where en = 1.
  - With en = 0 all stages hold their value.
  - Reset (active-low) still clears regardless of en.
  - For STAGES = 0, en is ignored.
- When undefined:
  - No en port.
  - Pipeline shifts on every clock edge (behaves as en tied to 1).

Test Plan:
1. STAGES=1, WIDTH=2; hold reset low 2 cycles, release; drive val_in = 2'b01 for one cycle at edge N -> val_out = 2'b01 exactly during cycle after edge N, 2'b00 before and after (matches start->done usage).
2. STAGES=4, WIDTH=8; stream val_in = 0x01,0x02,...,0x10 on consecutive edges with pipe_in = 1 -> val_out shows 0x01..0x10 in order starting 4 cycles later, pipe_out = 1 for exactly 16 cycles, no gaps.
3. STAGES=4, WIDTH=8; stream values, pull reset low for one edge while 3 values in flight -> val_out/pipe_out = 0 next cycle and remain 0 until new data emerges 4 cycles after reset release; in-flight values never appear.
4. STAGES=0, WIDTH=36; val_in = 36'hFFFFFFFFF, pipe_in = 1 -> val_out = 36'hFFFFFFFFF and pipe_out = 1 in the same cycle; reset low changes nothing.
5. pipe_in/val_in left unconnected, STAGES=3 -> val_out = 0 and pipe_out = 0 at all times after power-up.
6. With PIPE_DELAY_LINE_CLKEN_EN, STAGES=2: send 0xA5 with en = 1, then en = 0 for 5 cycles, then en = 1 -> 0xA5 reaches val_out only on the 2nd enabled edge; outputs frozen while en = 0; reset low with en = 0 still clears to 0.
